core_hazard_scoreboard: RTL

//  Parametrised forwarding/hazard unit for the ID stage. Handles NUM_SRC source operands

---
 rtl/core_hazard_scoreboard_pkg.sv | 18 +
 rtl/core_hazard_scoreboard_forward_select.sv | 34 +++
 rtl/core_hazard_scoreboard.sv | 108 ++++++++++
 3 files changed

// File: rtl/core_hazard_scoreboard_pkg.sv
// Shared constants and helpers for the ID-stage forwarding / hazard unit.
package core_hazard_scoreboard_pkg;

  localparam int unsigned FWD_NONE = 0;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  // Encoding used by the older two-stage core (MEM = 1, WB = 2).
  typedef enum logic [1:0] {
    FWD_REGFILE = 2'd0,
    FWD_MEM     = 2'd1,
    FWD_WB      = 2'd2
  } forward_type_t;

  function automatic int unsigned fwd_stage(input int unsigned k);
    return k + 1;
  endfunction

endpackage

// File: rtl/core_hazard_scoreboard_forward_select.sv
// Per-source bypass picker: the youngest matching downstream stage wins.
module core_forward_select
  import core_hazard_scoreboard_pkg::*;
#(
  parameter int NUM_FWD_STAGES = 2,
  parameter int FWD_W          = 2
) (
  input  logic [4:0]                  i_src,
  input  logic                        i_src_used,
  input  logic [NUM_FWD_STAGES*5-1:0] i_stage_rd,
  input  logic [NUM_FWD_STAGES-1:0]   i_stage_reg_write,
  input  logic [NUM_FWD_STAGES-1:0]   i_stage_data_ready,
  output logic [FWD_W-1:0]            o_sel,
  output logic                        o_not_ready
);

  logic w_found;

  always_comb begin
    o_sel       = FWD_W'(FWD_NONE);
    o_not_ready = 1'b0;
    w_found     = 1'b0;
    if (i_src_used && (i_src != REG_ZERO)) begin
      for (int k = 0; k < NUM_FWD_STAGES; k++) begin
        if (!w_found && i_stage_reg_write[k] && (i_stage_rd[k*5 +: 5] == i_src)) begin
          w_found     = 1'b1;
          o_sel       = FWD_W'(fwd_stage(k));
          o_not_ready = !i_stage_data_ready[k];
        end
      end
    end
  end

endmodule

// File: rtl/core_hazard_scoreboard.sv
// ID-stage forwarding select, stall generation and long-latency countdown scoreboard.
// Optional stall counter output is enabled by defining HAZARD_STATS_EN.
module core_hazard_scoreboard
  import core_hazard_scoreboard_pkg::*;
#(
  parameter  int NUM_SRC        = 2,
  parameter  int NUM_FWD_STAGES = 2,
  parameter  int NUM_REGS       = 32,
  parameter  int MAX_LAT        = 8,
  localparam int LAT_W          = $clog2(MAX_LAT + 1),
  localparam int FWD_W          = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_SRC*5-1:0]        ID_src,
  input  logic [NUM_SRC-1:0]          ID_src_used,
  input  logic [4:0]                  ID_rd,
  input  logic                        ID_reg_write,
  input  logic [LAT_W-1:0]            ID_lat,
  input  logic                        ID_valid,
  input  logic                        flush,
  input  logic [NUM_FWD_STAGES*5-1:0] stage_rd,
  input  logic [NUM_FWD_STAGES-1:0]   stage_reg_write,
  input  logic [NUM_FWD_STAGES-1:0]   stage_data_ready,
  output logic [NUM_SRC*FWD_W-1:0]    forward_sel,
  output logic                        stall
`ifdef HAZARD_STATS_EN
  , output logic [31:0]               stall_cycles
`endif
);

  logic [LAT_W-1:0]         r_busy_cnt [1:NUM_REGS-1];
  logic [LAT_W-1:0]         w_busy     [0:NUM_REGS-1];
  logic [NUM_SRC*FWD_W-1:0] w_sel;
  logic [NUM_SRC-1:0]       w_not_ready;
  logic [NUM_SRC-1:0]       w_src_haz;
  logic                     w_waw;
  logic                     w_stall;
  logic                     w_issue;

  // Register 0 reads as an idle counter so lookups never need a special case.
  always_comb begin
    w_busy[0] = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      w_busy[r] = r_busy_cnt[r];
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    logic [4:0] w_src;
    assign w_src = ID_src[g*5 +: 5];

    core_forward_select #(
      .NUM_FWD_STAGES(NUM_FWD_STAGES),
      .FWD_W         (FWD_W)
    ) u_fwd (
      .i_src             (w_src),
      .i_src_used        (ID_src_used[g]),
      .i_stage_rd        (stage_rd),
      .i_stage_reg_write (stage_reg_write),
      .i_stage_data_ready(stage_data_ready),
      .o_sel             (w_sel[g*FWD_W +: FWD_W]),
      .o_not_ready       (w_not_ready[g])
    );

    assign w_src_haz[g] = ID_src_used[g] && (w_src != REG_ZERO) &&
                          (w_not_ready[g] || (w_busy[w_src] != '0));
  end

  // A younger writer may issue once the older producer finishes no later than it does.
  assign w_waw   = ID_reg_write && (ID_rd != REG_ZERO) && (w_busy[ID_rd] > ID_lat);
  assign w_stall = !reset && ID_valid && !flush && ((|w_src_haz) || w_waw);
  assign w_issue = ID_valid && !w_stall && !flush && ID_reg_write && (ID_rd != REG_ZERO);

  assign stall       = w_stall;
  assign forward_sel = reset ? '0 : w_sel;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        r_busy_cnt[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (w_issue && (ID_rd == 5'(r)) && (ID_lat != '0)) begin
          r_busy_cnt[r] <= ID_lat;
        end else if (r_busy_cnt[r] != '0) begin
          r_busy_cnt[r] <= r_busy_cnt[r] - LAT_W'(1);
        end
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule
